// File: rtl/bw_pkg.sv
// Shared types and width helpers for the Baugh-Wooley multiplier and its
// downstream MAC accumulator.
package bw_pkg;

  // Accumulator FSM: collecting products, or holding a finished sum.
  typedef enum logic {ACC, HOLD} bw_acc_state_t;

  // Guard-bit-extended accumulator width: numTerms products of 2*numBit bits
  // each can be summed without overflow.
  function automatic int bw_acc_bits(input int numBit, input int numTerms);
    return 2 * numBit + $clog2(numTerms);
  endfunction

endpackage

// File: rtl/bw_multiplier.sv
// Combinational Baugh-Wooley signed multiplier. Partial products that involve
// exactly one sign bit are inverted. The correction constant 2^n + 2^(2n-1) is
// added so that the unsigned array sum equals the two's-complement product
// modulo 2^(2n).
module bw_multiplier #(
  parameter int numBit = 16
) (
  input  logic signed [numBit-1:0]   a,
  input  logic signed [numBit-1:0]   b,
  output logic signed [2*numBit-1:0] prod
);

  localparam int PW = 2 * numBit;
  localparam logic [PW-1:0] ONE = PW'(1);

  logic [PW-1:0] sum;

  // Sum the Baugh-Wooley partial-product array.
  always_comb begin
    sum = (ONE << numBit) + (ONE << (PW - 1));
    for (int i = 0; i < numBit - 1; i++) begin
      for (int j = 0; j < numBit - 1; j++) begin
        if (a[i] && b[j]) sum = sum + (ONE << (i + j));
      end
      if (!(a[i] && b[numBit-1])) sum = sum + (ONE << (i + numBit - 1));
      if (!(a[numBit-1] && b[i])) sum = sum + (ONE << (i + numBit - 1));
    end
    if (a[numBit-1] && b[numBit-1]) sum = sum + (ONE << (PW - 2));
    prod = sum;
  end

endmodule

// File: rtl/bw_mac_accumulator.sv
// MAC stage after the Baugh-Wooley multiplier. It sums numTerms signed products
// into a guard-bit-extended accumulator. Each finished sum is presented on a
// valid/ready output and held until the consumer accepts it. flush_in aborts
// the current sum.
module bw_mac_accumulator
  import bw_pkg::*;
#(
  parameter int numBit   = 16,
  parameter int numTerms = 8
) (
  input  logic                                       clk_in,
  input  logic                                       rst_in,
  input  logic                                       flush_in,
  input  logic signed [2*numBit-1:0]                 prod_in,
  input  logic                                       prod_valid_in,
  output logic                                       prod_ready_out,
  output logic signed [bw_acc_bits(numBit, numTerms)-1:0] res_out,
  output logic                                       res_valid_out,
  input  logic                                       res_ready_in,
  output logic [(($clog2(numTerms) > 0) ? $clog2(numTerms) : 1)-1:0] term_cnt_out
);

  localparam int accBits = bw_acc_bits(numBit, numTerms);
  localparam int cntBits = ($clog2(numTerms) > 0) ? $clog2(numTerms) : 1;
  localparam logic [cntBits-1:0] LAST_TERM = cntBits'(numTerms - 1);

  bw_acc_state_t             state, next_state;
  logic signed [accBits-1:0] acc;
  logic signed [accBits-1:0] prod_ext;
  logic signed [accBits-1:0] sum;
  logic                      xfer;
  logic                      last_term;

  // Product accepted: ready depends only on the state and on flush, never on prod_in.
  assign prod_ready_out = (state == ACC) && !flush_in;
  assign xfer           = prod_valid_in && prod_ready_out;
  assign last_term      = (term_cnt_out == LAST_TERM);

  // Sign-extend the product and form the running sum (wraps modulo 2^accBits).
  assign prod_ext = accBits'(prod_in);
  assign sum      = acc + prod_ext;

  // Next state: flush wins, otherwise finish a sum or release a held result.
  always_comb begin
    next_state = state;
    if (flush_in) begin
      next_state = ACC;
    end else begin
      case (state)
        ACC:     if (xfer && last_term) next_state = HOLD;
        HOLD:    if (res_ready_in)      next_state = ACC;
        default: next_state = ACC;
      endcase
    end
  end

  // State, accumulator, term counter and result register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state         <= ACC;
      acc           <= '0;
      term_cnt_out  <= '0;
      res_out       <= '0;
      res_valid_out <= 1'b0;
    end else begin
      state <= next_state;
      if (flush_in) begin
        acc           <= '0;
        term_cnt_out  <= '0;
        res_valid_out <= 1'b0;
      end else if (state == HOLD) begin
        if (res_ready_in) res_valid_out <= 1'b0;
      end else if (xfer) begin
        if (last_term) begin
          res_out       <= sum;
          res_valid_out <= 1'b1;
          acc           <= '0;
          term_cnt_out  <= '0;
        end else begin
          acc          <= sum;
          term_cnt_out <= term_cnt_out + cntBits'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_bw_mac_accumulator.sv
// Bench for bw_mac_accumulator, fed by bw_multiplier, with numBit=16 and numTerms=4.
// A behavioural model tracks the expected outputs on every cycle. Each finished
// sum is also checked against a hand-computed literal.
module tb_bw_mac_accumulator;

  localparam int NB = 16;
  localparam int NT = 4;
  localparam int AB = 34;
  localparam int CB = 2;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   flush = 1'b0;
  logic                   pvalid = 1'b0;
  logic                   rready = 1'b1;
  logic signed [NB-1:0]   m_op = '0;
  logic signed [NB-1:0]   n_op = '0;
  logic signed [2*NB-1:0] prod;
  logic                   pready;
  logic signed [AB-1:0]   res;
  logic                   rvalid;
  logic [CB-1:0]          tcnt;

  bw_multiplier #(.numBit(NB)) u_mul (
    .a    (m_op),
    .b    (n_op),
    .prod (prod)
  );

  bw_mac_accumulator #(.numBit(NB), .numTerms(NT)) dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .flush_in       (flush),
    .prod_in        (prod),
    .prod_valid_in  (pvalid),
    .prod_ready_out (pready),
    .res_out        (res),
    .res_valid_out  (rvalid),
    .res_ready_in   (rready),
    .term_cnt_out   (tcnt)
  );

  always #5 clk = ~clk;

  int     n_cmp = 0;
  int     n_fail = 0;
  int     tmo_events = 0;
  int     tmo_seen = 0;
  longint lit_q[$];
  longint lit;

  // Model state: are we holding a result, the partial sum, the term count, the last result.
  bit     m_hold = 1'b0;
  longint m_acc = 0;
  longint m_res = 0;
  int     m_cnt = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on each edge, then compare the DUT outputs just after it.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hold = 1'b0; m_acc = 0; m_cnt = 0; m_res = 0;
    end else if (flush) begin
      m_hold = 1'b0; m_acc = 0; m_cnt = 0;
    end else if (m_hold) begin
      if (rready) begin
        lit = (lit_q.size() > 0) ? lit_q.pop_front() : m_res + 1;
        chk("result_vs_literal", res, lit);
        chk("model_vs_literal", m_res, lit);
        m_hold = 1'b0;
      end
    end else if (pvalid) begin
      m_acc = m_acc + longint'(m_op) * longint'(n_op);
      m_cnt++;
      if (m_cnt == NT) begin
        m_res = m_acc; m_hold = 1'b1; m_acc = 0; m_cnt = 0;
      end
    end
    if (tmo_events != tmo_seen) begin
      chk("handshake_timeout", tmo_seen, tmo_events);
      tmo_seen = tmo_events;
    end
    #1;
    chk("res_valid", rvalid, m_hold);
    chk("term_cnt", tcnt, m_cnt);
    chk("prod_ready", pready, !m_hold && !flush);
    if (m_hold || rst) chk("res_out", res, m_hold ? m_res : 0);
  end

  // Present one operand pair starting at a falling edge; return at the falling edge after it is accepted.
  task automatic send(input int a, input int b);
    bit r;
    m_op = NB'(a); n_op = NB'(b); pvalid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      #1 r = pready;
      @(negedge clk);
      if (r) return;
    end
    tmo_events++;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic sum: 15, -15, 100, -1.
    lit_q.push_back(99);
    send(3, 5); send(-3, 5); send(10, 10); send(-1, 1);
    pvalid = 1'b0; repeat (3) @(negedge clk);

    // Extremes.
    lit_q.push_back(64'sd4294967296);
    repeat (4) send(-32768, -32768);
    pvalid = 1'b0; repeat (3) @(negedge clk);
    lit_q.push_back(-64'sd4294836224);
    repeat (4) send(-32768, 32767);
    pvalid = 1'b0; repeat (3) @(negedge clk);

    // Back-pressure: the result is held while the next product waits.
    rready = 1'b0;
    lit_q.push_back(-44);
    send(2, 3); send(-4, 5); send(6, 7); send(-8, 9);
    m_op = 16'sd10; n_op = 16'sd10; pvalid = 1'b1;
    repeat (5) @(negedge clk);
    rready = 1'b1;
    lit_q.push_back(114);
    send(10, 10); send(1, 1); send(2, 2); send(3, 3);
    pvalid = 1'b0; repeat (3) @(negedge clk);

    // Flush mid-sum with a product presented during the flush cycle.
    lit_q.push_back(10);
    send(7, 1); send(9, 1);
    m_op = 16'sd100; n_op = 16'sd1; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    send(1, 1); send(2, 1); send(3, 1); send(4, 1);
    pvalid = 1'b0; repeat (3) @(negedge clk);

    // Asynchronous reset between edges after two transfers.
    lit_q.push_back(20);
    send(11, 1); send(12, 1);
    pvalid = 1'b0;
    #3 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) send(5, 1);
    pvalid = 1'b0; repeat (4) @(negedge clk);

    if (lit_q.size() != 0) tmo_events++;
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
